// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Opcodes, FSM state encodings and the sign-fixup helper live here.
package muldiv_pkg;

    localparam int DATA_W_DEF = 32;
    // The sign helper works on the widest value the unit handles: a full product.
    localparam int NEG_W      = 2 * DATA_W_DEF;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MT    = 3'd5,   // MTHI / MTLO, selected by EX_Hi
        OP_MF    = 3'd6    // MFHI / MFLO, selected by EX_Hi
    } muldiv_op_t;

    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t IDLE = 2'd0;
    localparam muldiv_state_t MUL  = 2'd1;
    localparam muldiv_state_t DIV  = 2'd2;
    localparam muldiv_state_t FIX  = 2'd3;

    function automatic logic [NEG_W-1:0] neg_if(input logic [NEG_W-1:0] val, input logic flag);
        return flag ? -val : val;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(parameter int DATA_W = DATA_W_DEF);

    muldiv_op_t        EX_Op;
    logic              EX_Hi;
    logic              EX_Valid;
    logic              EX_Stall;
    logic [DATA_W-1:0] EX_A;
    logic [DATA_W-1:0] EX_B;
    logic              EX_ALU_Stall;
    logic [DATA_W-1:0] EX_Result;

    modport master (
        output EX_Op, EX_Hi, EX_Valid, EX_Stall, EX_A, EX_B,
        input  EX_ALU_Stall, EX_Result
    );

    modport slave (
        input  EX_Op, EX_Hi, EX_Valid, EX_Stall, EX_A, EX_B,
        output EX_ALU_Stall, EX_Result
    );

endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 datapath: shift-add product accumulator and restoring divider,
// stepped one bit per cycle by the controller in muldiv_unit.
module muldiv_datapath #(
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load,
    input  logic                mul_step,
    input  logic                div_step,
    input  logic [DATA_W-1:0]   a_mag,
    input  logic [DATA_W-1:0]   b_mag,
    output logic [2*DATA_W-1:0] product,
    output logic [DATA_W-1:0]   quotient,
    output logic [DATA_W:0]     remainder
);

    logic [2*DATA_W-1:0] prod_reg;
    logic [DATA_W-1:0]   opnd_reg;
    logic [DATA_W-1:0]   quo_reg;
    logic [DATA_W:0]     rem_reg;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W+1:0]   trial;
    logic                take;

    // Multiplier sits in the low half and is consumed LSB first.
    assign mul_sum   = {1'b0, prod_reg[2*DATA_W-1:DATA_W]}
                     + (prod_reg[0] ? {1'b0, opnd_reg} : '0);

    // Trial subtraction; a borrow means the old remainder is kept (restored).
    assign rem_shift = {rem_reg[DATA_W-1:0], quo_reg[DATA_W-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, opnd_reg};
    assign take      = !trial[DATA_W+1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod_reg <= '0;
            opnd_reg <= '0;
            quo_reg  <= '0;
            rem_reg  <= '0;
        end else if (load) begin
            prod_reg <= {{DATA_W{1'b0}}, a_mag};
            opnd_reg <= b_mag;
            quo_reg  <= a_mag;
            rem_reg  <= '0;
        end else if (mul_step) begin
            prod_reg <= {mul_sum, prod_reg[DATA_W-1:1]};
        end else if (div_step) begin
            rem_reg  <= take ? trial[DATA_W:0] : rem_shift;
            quo_reg  <= {quo_reg[DATA_W-2:0], take};
        end
    end

    assign product   = prod_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO; stalls any HI/LO user while
// a 32-cycle iteration plus one sign-fixup cycle is in flight.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,   // up to DATA_W_DEF
    parameter int ITER   = DATA_W
) (
    input  logic     clock,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    localparam int CNT_W  = $clog2(ITER);
    localparam int PROD_W = 2 * DATA_W;

    muldiv_state_t     state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              neg_p_reg;
    logic              neg_r_reg;
    logic              div_zero_reg;
    logic              op_div_reg;
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    logic              live_op, busy, issue, last_iter;
    logic              is_mul_op, is_div_op, is_signed_op, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [PROD_W-1:0] product, prod_fix;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W:0]   remainder;
    logic [DATA_W-1:0] fix_hi, fix_lo;

    assign live_op          = bus.EX_Valid && (bus.EX_Op != OP_NONE);
    assign busy             = (state_reg != IDLE);
    // Independent of EX_Stall so the hazard controller sees no loop.
    assign bus.EX_ALU_Stall = live_op && busy;
    assign issue            = live_op && !busy && !bus.EX_Stall;
    assign bus.EX_Result    = bus.EX_Hi ? hi_reg : lo_reg;

    assign is_mul_op    = (bus.EX_Op == OP_MULT) || (bus.EX_Op == OP_MULTU);
    assign is_div_op    = (bus.EX_Op == OP_DIV)  || (bus.EX_Op == OP_DIVU);
    assign is_signed_op = (bus.EX_Op == OP_MULT) || (bus.EX_Op == OP_DIV);
    assign a_neg        = is_signed_op && bus.EX_A[DATA_W-1];
    assign b_neg        = is_signed_op && bus.EX_B[DATA_W-1];
    assign a_mag        = DATA_W'(neg_if(NEG_W'(bus.EX_A), a_neg));
    assign b_mag        = DATA_W'(neg_if(NEG_W'(bus.EX_B), b_neg));
    assign last_iter    = (count_reg == CNT_W'(ITER - 1));

    muldiv_datapath #(.DATA_W(DATA_W)) u_datapath (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (issue && (is_mul_op || is_div_op)),
        .mul_step  (state_reg == MUL),
        .div_step  (state_reg == DIV),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Divide by zero leaves the all-ones quotient unsigned regardless of signs.
    always_comb begin
        prod_fix = PROD_W'(neg_if(NEG_W'(product), neg_p_reg));
        fix_hi   = prod_fix[PROD_W-1:DATA_W];
        fix_lo   = prod_fix[DATA_W-1:0];
        if (op_div_reg) begin
            fix_hi = DATA_W'(neg_if(NEG_W'(remainder), neg_r_reg));
            fix_lo = DATA_W'(neg_if(NEG_W'(quotient), neg_p_reg && !div_zero_reg));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            neg_p_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            op_div_reg   <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        count_reg    <= '0;
                        neg_p_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg && is_div_op;
                        div_zero_reg <= (bus.EX_B == '0);
                        op_div_reg   <= is_div_op;
                        if (is_mul_op) begin
                            state_reg <= MUL;
                        end else if (is_div_op) begin
                            state_reg <= DIV;
                        end else if (bus.EX_Op == OP_MT) begin
                            if (bus.EX_Hi) hi_reg <= bus.EX_A;
                            else           lo_reg <= bus.EX_A;
                        end
                    end
                end
                MUL, DIV: begin
                    count_reg <= count_reg + CNT_W'(1);
                    if (last_iter) state_reg <= FIX;
                end
                default: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
